eh2_lsu_ecc_scrub: RTL and testbench
====================================

EH2_LSU_ECC_SCRUB -- requirements
Module: eh2_lsu_ecc_scrub

Interface
REQ-001 SHALL have parameter NUM_BANKS, default 2, meaning the number of DCCM banks reporting ECC results per cycle (1..4).
REQ-002 SHALL have parameter QDEPTH, default 4, meaning the number of correction-queue entries (power of 2, 2..16).
REQ-003 SHALL have parameter ADDR_WIDTH, default 16, meaning the DCCM word-address width.
REQ-004 SHALL have parameter CNT_WIDTH, default 16, meaning the error-counter width.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state is rising-edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-007 SHALL have port ecc_disable, input, 1 bit: suppresses capture and counting.
REQ-008 SHALL have port err_valid, input, 1 bit: bank results are valid this cycle.
REQ-009 SHALL have port err_single, input, NUM_BANKS bits: per-bank correctable error.
REQ-010 SHALL have port err_double, input, NUM_BANKS bits: per-bank uncorrectable error.
REQ-011 SHALL have port err_addr, input, NUM_BANKS*ADDR_WIDTH bits: per-bank word address; bank i occupies slice i.
REQ-012 SHALL have port err_data, input, NUM_BANKS*32 bits: per-bank corrected data.
REQ-013 SHALL have port wr_req, output, 1 bit: request for a DCCM correction write.
REQ-014 SHALL have port wr_gnt, input, 1 bit: DCCM write port granted.
REQ-015 SHALL have port wr_addr, output, ADDR_WIDTH bits: correction write address.
REQ-016 SHALL have port wr_data, output, 39 bits: {ecc[6:0], data[31:0]}, with ecc from rvecc_encode.
REQ-017 SHALL have port q_count, output, $clog2(QDEPTH)+1 bits: current queue occupancy.
REQ-018 SHALL have port q_overflow, output, 1 bit: sticky flag, set when a correction was dropped.
REQ-019 SHALL have port single_cnt, output, CNT_WIDTH bits: saturating count of correctable errors.
REQ-020 SHALL have port double_cnt, output, CNT_WIDTH bits: saturating count of uncorrectable errors.
REQ-021 SHALL have port thresh, input, CNT_WIDTH bits: interrupt threshold; 0 disables the interrupt.
REQ-022 SHALL have port thresh_irq, output, 1 bit: sticky threshold interrupt.
REQ-023 SHALL have port cnt_clr, input, 1 bit: clears the counters, thresh_irq and q_overflow.

Function
REQ-024 Capture SHALL occur only for bank i with err_valid & err_single[i] & ~err_double[i] & ~ecc_disable.
REQ-025 Up to NUM_BANKS entries SHALL be enqueued per cycle, in ascending bank order, and SHALL be visible at q_count the next cycle.
REQ-026 A capture SHALL be merged (not enqueued) if its address equals a valid queue entry's address or a lower-index bank's capture in the same cycle.
REQ-027 Free space SHALL be QDEPTH minus the registered occupancy; a pop in the same cycle SHALL NOT free space for that cycle's enqueues.
REQ-028 Captures beyond free space SHALL be dropped, highest bank first, and q_overflow SHALL be set on the next edge.
REQ-029 The write FSM SHALL have states IDLE and REQ: IDLE->REQ when q_count!=0; REQ->IDLE on wr_gnt when occupancy after pop is 0; otherwise it stays in REQ.
REQ-030 wr_req SHALL equal (state==REQ); wr_addr/wr_data SHALL present the queue head and SHALL hold stable while wr_req is high without wr_gnt.
REQ-031 wr_gnt SHALL be ignored when wr_req is low; wr_req & wr_gnt SHALL pop the head on that edge.
REQ-032 single_cnt SHALL add the number of qualifying single-error banks per cycle (including merged and dropped captures) and saturate at all-ones.
REQ-033 double_cnt SHALL add popcount(err_double) when err_valid & ~ecc_disable, saturating; double errors SHALL never be enqueued.
REQ-034 thresh_irq SHALL set on the edge after single_cnt >= thresh with thresh != 0, and SHALL remain set until cnt_clr or rst.
REQ-035 cnt_clr SHALL zero single_cnt, double_cnt, thresh_irq and q_overflow, and SHALL discard that cycle's count increments; queue contents SHALL be unaffected.
REQ-036 ecc_disable SHALL NOT stop draining of entries already queued.
REQ-037 Head/tail pointers SHALL wrap modulo QDEPTH; full (q_count==QDEPTH) and empty SHALL be distinguished by the extra occupancy bit.

Reset
REQ-038 On rst, the queue SHALL empty and the FSM SHALL go to IDLE; wr_req, q_count, q_overflow, single_cnt, double_cnt and thresh_irq SHALL be 0 on the next edge.
REQ-039 wr_addr and wr_data SHALL read 0 while the queue is empty.
REQ-040 rst asserted mid-REQ SHALL abandon the pending write, with no pop credited for a coincident wr_gnt.

Verification
REQ-041 Stimulus: bank0 single error, addr 0x10, data 0xDEADBEEF; wr_gnt high two cycles later -> wr_req is high one cycle after capture with wr_addr=0x10 and correct ecc; q_count returns to 0 after the grant.
REQ-042 Stimulus: bank0 and bank1 both report addr 0x20 in one cycle -> q_count=1 and single_cnt=2.
REQ-043 Stimulus: QDEPTH=4 with 3 entries queued, wr_gnt low, and 2 captures -> the bank0 capture is enqueued (q_count=4), bank1 is dropped, q_overflow=1.
REQ-044 Stimulus: thresh=3, then 3 single errors on separate cycles -> thresh_irq=1 the cycle after the third; cnt_clr coincident with a 4th error -> single_cnt=0 and thresh_irq=0.
REQ-045 Stimulus: err_double=2'b11 with ecc_disable=0 -> double_cnt=2 and q_count unchanged; the same stimulus with ecc_disable=1 -> no change.
REQ-046 Stimulus: rst during REQ with wr_gnt=1 -> all outputs 0 the next cycle and no further wr_req.

Source files
------------

// File: rtl/eh2_lsu_ecc_scrub.sv
// DCCM ECC scrubber: captures correctable-error words reported by the DCCM
// banks, queues unique addresses, and writes the corrected data back with
// fresh ECC through a request/grant write port. Also keeps saturating
// single/double error counters and a sticky threshold interrupt.
module eh2_lsu_ecc_scrub #(
   parameter int NUM_BANKS  = 2,
   parameter int QDEPTH     = 4,
   parameter int ADDR_WIDTH = 16,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            ecc_disable,
   input  logic                            err_valid,
   input  logic [NUM_BANKS-1:0]            err_single,
   input  logic [NUM_BANKS-1:0]            err_double,
   input  logic [NUM_BANKS*ADDR_WIDTH-1:0] err_addr,
   input  logic [NUM_BANKS*32-1:0]         err_data,
   output logic                            wr_req,
   input  logic                            wr_gnt,
   output logic [ADDR_WIDTH-1:0]           wr_addr,
   output logic [38:0]                     wr_data,
   output logic [$clog2(QDEPTH):0]         q_count,
   output logic                            q_overflow,
   output logic [CNT_WIDTH-1:0]            single_cnt,
   output logic [CNT_WIDTH-1:0]            double_cnt,
   input  logic [CNT_WIDTH-1:0]            thresh,
   output logic                            thresh_irq,
   input  logic                            cnt_clr
);

   localparam int PW = $clog2(QDEPTH);
   localparam int CW = PW + 1;
   localparam int BW = $clog2(NUM_BANKS + 1);

   typedef enum logic {IDLE, REQ} state_t;

   // Hamming(38,32) check bits plus overall parity. Data bits occupy the
   // codeword positions that are not powers of two; check bit k covers every
   // position with bit k set.
   function automatic logic [6:0] ecc_encode(input logic [31:0] d);
      logic [6:0] e;
      int         di;
      e  = '0;
      di = 0;
      for (int p = 1; p < 39; p++) begin
         if ((p & (p - 1)) != 0) begin
            for (int k = 0; k < 6; k++) begin
               if (((p >> k) & 1) != 0) e[k] = e[k] ^ d[di[4:0]];
            end
            di = di + 1;
         end
      end
      e[6] = (^d) ^ (^e[5:0]);
      return e;
   endfunction

   // Counter add that sticks at all-ones instead of wrapping.
   function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                     input logic [BW-1:0]        b);
      logic [CNT_WIDTH:0] s;
      s = {1'b0, a} + (CNT_WIDTH+1)'(b);
      return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
   endfunction

   state_t                state_q, state_d;
   logic [PW-1:0]         head_q, tail_q;
   logic [CW-1:0]         count_q, count_d;
   logic                  ovf_q, irq_q;
   logic [CNT_WIDTH-1:0]  sgl_q, dbl_q;
   logic [ADDR_WIDTH-1:0] addr_mem_q [QDEPTH];
   logic [31:0]           data_mem_q [QDEPTH];

   logic [ADDR_WIDTH-1:0] bank_addr [NUM_BANKS];
   logic [31:0]           bank_data [NUM_BANKS];
   logic [NUM_BANKS-1:0]  cap, dup, accept;
   logic [PW-1:0]         slot_idx [NUM_BANKS];
   logic [QDEPTH-1:0]     slot_valid;
   logic [CW-1:0]         free, n_acc;
   logic                  drop, pop;
   logic [BW-1:0]         sgl_inc, dbl_inc;
   logic [31:0]           head_data;

   // Per-bank slices and capture qualification.
   generate
      for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
         assign bank_addr[gi] = err_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
         assign bank_data[gi] = err_data[gi*32 +: 32];
         assign cap[gi]       = err_valid & err_single[gi] & ~err_double[gi] & ~ecc_disable;
      end
   endgenerate

   // A slot holds a live entry when its distance from head is below occupancy.
   generate
      for (genvar gi = 0; gi < QDEPTH; gi++) begin : g_slot
         assign slot_valid[gi] = {1'b0, PW'(gi) - head_q} < count_q;
      end
   endgenerate

   // Free space comes from registered occupancy only; a same-cycle pop
   // does not make room for this cycle's captures.
   assign free = CW'(QDEPTH) - count_q;
   assign pop  = (state_q == REQ) & wr_gnt;

   // Merge duplicates, then enqueue unique captures in bank order until full.
   always_comb begin
      dup     = '0;
      accept  = '0;
      drop    = 1'b0;
      n_acc   = '0;
      sgl_inc = '0;
      dbl_inc = '0;
      for (int i = 0; i < NUM_BANKS; i++) slot_idx[i] = '0;
      for (int i = 0; i < NUM_BANKS; i++) begin
         sgl_inc = sgl_inc + BW'(cap[i]);
         if (err_valid && !ecc_disable) dbl_inc = dbl_inc + BW'(err_double[i]);
         if (cap[i]) begin
            for (int j = 0; j < QDEPTH; j++) begin
               if (slot_valid[j] && (addr_mem_q[j] == bank_addr[i])) dup[i] = 1'b1;
            end
            for (int j = 0; j < i; j++) begin
               if (cap[j] && (bank_addr[j] == bank_addr[i])) dup[i] = 1'b1;
            end
            if (!dup[i]) begin
               if (n_acc < free) begin
                  accept[i]   = 1'b1;
                  slot_idx[i] = tail_q + n_acc[PW-1:0];
                  n_acc       = n_acc + CW'(1);
               end else begin
                  drop = 1'b1;
               end
            end
         end
      end
   end

   assign count_d = count_q + n_acc - CW'(pop);

   // Write FSM next state: request while anything is queued.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (count_q != '0) state_d = REQ;
         REQ:     if (wr_gnt && (count_d == '0)) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Queue pointers, FSM state, counters and sticky flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         irq_q   <= 1'b0;
         sgl_q   <= '0;
         dbl_q   <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_q + PW'(pop);
         tail_q  <= tail_q + n_acc[PW-1:0];
         count_q <= count_d;
         if (cnt_clr) begin
            ovf_q <= 1'b0;
            irq_q <= 1'b0;
            sgl_q <= '0;
            dbl_q <= '0;
         end else begin
            ovf_q <= ovf_q | drop;
            irq_q <= irq_q | ((thresh != '0) && (sgl_q >= thresh));
            sgl_q <= sat_add(sgl_q, sgl_inc);
            dbl_q <= sat_add(dbl_q, dbl_inc);
         end
      end
   end

   // Queue storage writes; only free slots at the tail are ever written.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NUM_BANKS; i++) begin
            if (accept[i]) begin
               addr_mem_q[slot_idx[i]] <= bank_addr[i];
               data_mem_q[slot_idx[i]] <= bank_data[i];
            end
         end
      end
   end

   assign head_data  = data_mem_q[head_q];
   assign wr_req     = (state_q == REQ);
   assign wr_addr    = (count_q == '0) ? '0 : addr_mem_q[head_q];
   assign wr_data    = (count_q == '0) ? '0 : {ecc_encode(head_data), head_data};
   assign q_count    = count_q;
   assign q_overflow = ovf_q;
   assign single_cnt = sgl_q;
   assign double_cnt = dbl_q;
   assign thresh_irq = irq_q;

endmodule

// File: tb/tb_eh2_lsu_ecc_scrub.sv
// Bench for eh2_lsu_ecc_scrub: expected correction writes go into a
// scoreboard queue as errors are injected and are compared at each grant.
module tb_eh2_lsu_ecc_scrub;

   logic        clk = 1'b0;
   logic        rst;
   logic        ecc_disable;
   logic        err_valid;
   logic [1:0]  err_single;
   logic [1:0]  err_double;
   logic [31:0] err_addr;
   logic [63:0] err_data;
   logic        wr_req;
   logic        wr_gnt;
   logic [15:0] wr_addr;
   logic [38:0] wr_data;
   logic [2:0]  q_count;
   logic        q_overflow;
   logic [15:0] single_cnt;
   logic [15:0] double_cnt;
   logic [15:0] thresh;
   logic        thresh_irq;
   logic        cnt_clr;

   typedef struct {
      logic [15:0] addr;
      logic [31:0] data;
   } sb_t;

   sb_t sb[$];
   int  vectors     = 0;
   int  miscompares = 0;

   eh2_lsu_ecc_scrub #(
      .NUM_BANKS (2),
      .QDEPTH    (4),
      .ADDR_WIDTH(16),
      .CNT_WIDTH (16)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .ecc_disable(ecc_disable),
      .err_valid  (err_valid),
      .err_single (err_single),
      .err_double (err_double),
      .err_addr   (err_addr),
      .err_data   (err_data),
      .wr_req     (wr_req),
      .wr_gnt     (wr_gnt),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .q_count    (q_count),
      .q_overflow (q_overflow),
      .single_cnt (single_cnt),
      .double_cnt (double_cnt),
      .thresh     (thresh),
      .thresh_irq (thresh_irq),
      .cnt_clr    (cnt_clr)
   );

   always #5 clk = ~clk;

   // Reference ECC from the explicit per-check-bit data masks.
   function automatic logic [6:0] ref_ecc(input logic [31:0] d);
      logic [6:0] e;
      e[0] = ^(d & 32'h56AAAD5B);
      e[1] = ^(d & 32'h9B33366D);
      e[2] = ^(d & 32'hE3C3C78E);
      e[3] = ^(d & 32'h03FC07F0);
      e[4] = ^(d & 32'h03FFF800);
      e[5] = ^(d & 32'hFC000000);
      e[6] = (^d) ^ (^e[5:0]);
      return e;
   endfunction

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One cycle of bank results, then the inputs go idle.
   task automatic drive(input logic [1:0] s, input logic [1:0] dbl,
                        input logic [15:0] a0, input logic [31:0] d0,
                        input logic [15:0] a1, input logic [31:0] d1);
      err_valid  = 1'b1;
      err_single = s;
      err_double = dbl;
      err_addr   = {a1, a0};
      err_data   = {d1, d0};
      step();
      err_valid  = 1'b0;
      err_single = 2'b00;
      err_double = 2'b00;
   endtask

   // Wait (bounded) for a request, compare the head against the scoreboard, grant it.
   task automatic grant_head(input string tag);
      int  n;
      sb_t e;
      n = 0;
      while (wr_req !== 1'b1 && n < 8) begin
         step();
         n++;
      end
      check_val({tag, "_req"}, 64'(wr_req), 64'd1);
      if (sb.size() == 0) begin
         check_val({tag, "_sb_nonempty"}, 64'(sb.size()), 64'd1);
         return;
      end
      e = sb.pop_front();
      check_val({tag, "_addr"}, 64'(wr_addr), 64'(e.addr));
      check_val({tag, "_data"}, 64'(wr_data), 64'({ref_ecc(e.data), e.data}));
      $display("grant %s addr=0x%04h data=0x%010h", tag, wr_addr, wr_data);
      wr_gnt = 1'b1;
      step();
      wr_gnt = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, "_wr_req"},     64'(wr_req),     64'd0);
      check_val({tag, "_q_count"},    64'(q_count),    64'd0);
      check_val({tag, "_q_overflow"}, 64'(q_overflow), 64'd0);
      check_val({tag, "_single"},     64'(single_cnt), 64'd0);
      check_val({tag, "_double"},     64'(double_cnt), 64'd0);
      check_val({tag, "_irq"},        64'(thresh_irq), 64'd0);
      check_val({tag, "_wr_addr"},    64'(wr_addr),    64'd0);
      check_val({tag, "_wr_data"},    64'(wr_data),    64'd0);
   endtask

   initial begin
      rst         = 1'b1;
      ecc_disable = 1'b0;
      err_valid   = 1'b0;
      err_single  = 2'b00;
      err_double  = 2'b00;
      err_addr    = '0;
      err_data    = '0;
      wr_gnt      = 1'b0;
      thresh      = '0;
      cnt_clr     = 1'b0;
      step();
      step();
      rst = 1'b0;
      check_all_zero("reset");

      // Single correctable error drained through one grant.
      drive(2'b01, 2'b00, 16'h0010, 32'hDEADBEEF, 16'h0000, 32'h0);
      sb.push_back('{16'h0010, 32'hDEADBEEF});
      check_val("t1_qcount", 64'(q_count), 64'(sb.size()));
      check_val("t1_req_early", 64'(wr_req), 64'd0);
      check_val("t1_single", 64'(single_cnt), 64'd1);
      step();
      check_val("t1_req_next", 64'(wr_req), 64'd1);
      grant_head("t1");
      check_val("t1_qcount_after", 64'(q_count), 64'(sb.size()));
      check_val("t1_req_after", 64'(wr_req), 64'd0);

      // Two banks, same address: one entry, two counts.
      drive(2'b11, 2'b00, 16'h0020, 32'h12345678, 16'h0020, 32'h12345678);
      sb.push_back('{16'h0020, 32'h12345678});
      check_val("t2_qcount", 64'(q_count), 64'd1);
      check_val("t2_single", 64'(single_cnt), 64'd3);
      grant_head("t2");
      check_val("t2_qcount_after", 64'(q_count), 64'd0);

      // Fill to 3, merge against a queued address, then overflow on bank1.
      drive(2'b11, 2'b00, 16'h0030, 32'h00000030, 16'h0031, 32'hA5A5_0031);
      sb.push_back('{16'h0030, 32'h00000030});
      sb.push_back('{16'h0031, 32'hA5A5_0031});
      drive(2'b01, 2'b00, 16'h0032, 32'hFFFF_FFFF, 16'h0000, 32'h0);
      sb.push_back('{16'h0032, 32'hFFFF_FFFF});
      check_val("t3_qcount3", 64'(q_count), 64'd3);
      drive(2'b01, 2'b00, 16'h0031, 32'h1111_1111, 16'h0000, 32'h0);
      check_val("t3_merge_qcount", 64'(q_count), 64'd3);
      drive(2'b11, 2'b00, 16'h0033, 32'h8000_0001, 16'h0034, 32'h7654_3210);
      sb.push_back('{16'h0033, 32'h8000_0001});
      check_val("t3_full_qcount", 64'(q_count), 64'd4);
      check_val("t3_overflow", 64'(q_overflow), 64'd1);
      check_val("t3_single", 64'(single_cnt), 64'd9);
      check_val("t3_hold_addr0", 64'(wr_addr), 64'h30);
      step();
      check_val("t3_hold_req", 64'(wr_req), 64'd1);
      check_val("t3_hold_addr1", 64'(wr_addr), 64'h30);
      for (int i = 0; i < 4; i++) grant_head($sformatf("t3_g%0d", i));
      check_val("t3_drained_qcount", 64'(q_count), 64'd0);
      check_val("t3_drained_req", 64'(wr_req), 64'd0);
      check_val("t3_empty_addr", 64'(wr_addr), 64'd0);
      check_val("t3_empty_data", 64'(wr_data), 64'd0);
      check_val("t3_ovf_sticky", 64'(q_overflow), 64'd1);

      // Threshold interrupt and clear.
      cnt_clr = 1'b1;
      step();
      cnt_clr = 1'b0;
      check_val("t4_clr_single", 64'(single_cnt), 64'd0);
      check_val("t4_clr_ovf", 64'(q_overflow), 64'd0);
      thresh = 16'd3;
      for (int i = 0; i < 3; i++) begin
         drive(2'b01, 2'b00, 16'(16'h0040 + i), 32'(32'hC0DE_0000 + i), 16'h0000, 32'h0);
         sb.push_back('{16'(16'h0040 + i), 32'(32'hC0DE_0000 + i)});
         if (i < 2) step();
      end
      check_val("t4_single3", 64'(single_cnt), 64'd3);
      check_val("t4_irq_not_yet", 64'(thresh_irq), 64'd0);
      step();
      check_val("t4_irq_set", 64'(thresh_irq), 64'd1);
      cnt_clr = 1'b1;
      drive(2'b01, 2'b00, 16'h0043, 32'hC0DE_0003, 16'h0000, 32'h0);
      cnt_clr = 1'b0;
      sb.push_back('{16'h0043, 32'hC0DE_0003});
      check_val("t4_clr_single4", 64'(single_cnt), 64'd0);
      check_val("t4_clr_irq", 64'(thresh_irq), 64'd0);
      check_val("t4_queue_kept", 64'(q_count), 64'd4);
      step();
      check_val("t4_irq_stays0", 64'(thresh_irq), 64'd0);
      thresh = '0;
      for (int i = 0; i < 4; i++) grant_head($sformatf("t4_g%0d", i));

      // Double errors: counted, never queued; ecc_disable suppresses everything.
      drive(2'b00, 2'b11, 16'h0050, 32'h0, 16'h0051, 32'h0);
      check_val("t5_double", 64'(double_cnt), 64'd2);
      check_val("t5_qcount", 64'(q_count), 64'd0);
      ecc_disable = 1'b1;
      drive(2'b01, 2'b10, 16'h0052, 32'h5252_5252, 16'h0053, 32'h0);
      ecc_disable = 1'b0;
      check_val("t5_dis_double", 64'(double_cnt), 64'd2);
      check_val("t5_dis_single", 64'(single_cnt), 64'd0);
      check_val("t5_dis_qcount", 64'(q_count), 64'd0);
      drive(2'b01, 2'b01, 16'h0054, 32'h5454_5454, 16'h0000, 32'h0);
      check_val("t5_sd_double", 64'(double_cnt), 64'd3);
      check_val("t5_sd_single", 64'(single_cnt), 64'd0);
      check_val("t5_sd_qcount", 64'(q_count), 64'd0);

      // Draining continues with ecc_disable asserted.
      drive(2'b01, 2'b00, 16'h0055, 32'h0BAD_F00D, 16'h0000, 32'h0);
      sb.push_back('{16'h0055, 32'h0BAD_F00D});
      ecc_disable = 1'b1;
      grant_head("t6");
      ecc_disable = 1'b0;
      check_val("t6_qcount", 64'(q_count), 64'd0);

      // Reset during a pending request with a coincident grant.
      drive(2'b11, 2'b00, 16'h0060, 32'h6060_6060, 16'h0061, 32'h6161_6161);
      step();
      check_val("t7_req_before", 64'(wr_req), 64'd1);
      rst    = 1'b1;
      wr_gnt = 1'b1;
      step();
      rst    = 1'b0;
      wr_gnt = 1'b0;
      sb.delete();
      check_all_zero("t7_rst");
      for (int i = 0; i < 3; i++) begin
         step();
         check_val($sformatf("t7_noreq%0d", i), 64'(wr_req), 64'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
